// File: rtl/ac97_cra_queue.sv
// ac97_cra_queue: queued AC97 codec register access engine, one command per frame on slots 1/2
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cmd_we, cmd_din       command push: [31]=read, [22:16]=register index, [15:0]=write data
//   cmd_full, cmd_level   registered FIFO status (level excludes the command in flight)
//   cmd_drop              one-cycle pulse after a push was refused because the FIFO was full
//   valid                 frame slot-valid window from the codec interface
//   out_slt1, out_slt2    outgoing command/address and write data slots
//   in_slt1, in_slt2      received status address and data slots
//   crac_valid, crac_wr   slots carry a command this frame / that command is a write
//   wr_done               one-cycle pulse once a write has been transmitted
//   rd_valid, rd_data     one-cycle pulse when rd_data captures read data
//   rd_timeout            one-cycle pulse when a read is abandoned
//   busy                  engine is not idle
module ac97_cra_queue #(
    parameter int DEPTH          = 4,
    parameter int AW             = 2,
    parameter int TIMEOUT_FRAMES = 4,
    parameter bit ADDR_CHECK     = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_we,
    input  logic [31:0]   cmd_din,
    output logic          cmd_full,
    output logic [AW:0]   cmd_level,
    output logic          cmd_drop,
    input  logic          valid,
    output logic [19:0]   out_slt1,
    output logic [19:0]   out_slt2,
    input  logic [19:0]   in_slt1,
    input  logic [19:0]   in_slt2,
    output logic          crac_valid,
    output logic          crac_wr,
    output logic          wr_done,
    output logic          rd_valid,
    output logic [15:0]   rd_data,
    output logic          rd_timeout,
    output logic          busy
);
    localparam logic [1:0]  IDLE       = 2'd0;
    localparam logic [1:0]  ARM        = 2'd1;
    localparam logic [1:0]  SEND       = 2'd2;
    localparam logic [1:0]  RD_WAIT    = 2'd3;
    localparam logic [AW:0] FULL_LVL   = (AW+1)'(DEPTH);
    localparam logic [7:0]  LAST_FRAME = 8'(TIMEOUT_FRAMES - 1);

    // Commands are stored compactly as {read, index[6:0], data[15:0]}
    logic [23:0]   mem [DEPTH];
    logic [23:0]   cmd_q;
    logic [AW-1:0] wp, rp;
    logic [1:0]    state;
    logic [7:0]    fcnt;
    logic          valid_r, valid_pe, valid_ne;
    logic          push, pop, rd_cmd, rd_match;
    logic          unused_bits;

    assign unused_bits = ^{cmd_din[30:23], in_slt1[19], in_slt1[11:0], in_slt2[3:0]};
    assign valid_pe    = valid & ~valid_r;
    assign valid_ne    = ~valid & valid_r;
    assign push        = cmd_we & ~cmd_full;
    // Popping only outside the valid window keeps a command from starting mid-frame
    assign pop         = (state == IDLE) & (cmd_level != '0) & ~valid;
    assign rd_cmd      = cmd_q[23];
    assign rd_match    = !ADDR_CHECK || (in_slt1[18:12] == cmd_q[22:16]);
    assign out_slt1    = {rd_cmd, cmd_q[22:16], 12'h0};
    assign out_slt2    = {rd_cmd ? 16'h0 : cmd_q[15:0], 4'h0};
    assign crac_valid  = (state == ARM) | (state == SEND);
    assign crac_wr     = crac_valid & ~rd_cmd;
    assign busy        = state != IDLE;

    always_ff @(posedge clk)
        if (push) mem[wp] <= {cmd_din[31], cmd_din[22:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            wp         <= '0;
            rp         <= '0;
            cmd_level  <= '0;
            cmd_full   <= 1'b0;
            cmd_drop   <= 1'b0;
            cmd_q      <= '0;
            state      <= IDLE;
            fcnt       <= '0;
            valid_r    <= 1'b0;
            wr_done    <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            rd_timeout <= 1'b0;
        end else begin
            valid_r    <= valid;
            cmd_drop   <= cmd_we & cmd_full;
            wr_done    <= 1'b0;
            rd_valid   <= 1'b0;
            rd_timeout <= 1'b0;
            if (push) wp <= wp + 1'b1;
            if (pop) begin
                cmd_q <= mem[rp];
                rp    <= rp + 1'b1;
            end
            if (push & ~pop) begin
                cmd_level <= cmd_level + 1'b1;
                cmd_full  <= cmd_level == FULL_LVL - 1'b1;
            end else if (pop & ~push) begin
                cmd_level <= cmd_level - 1'b1;
                cmd_full  <= 1'b0;
            end
            case (state)
                IDLE:    if (pop) state <= ARM;
                ARM:     if (valid_pe) state <= SEND;
                SEND:
                    if (valid_ne) begin
                        if (rd_cmd) begin
                            fcnt  <= '0;
                            state <= RD_WAIT;
                        end else begin
                            wr_done <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                RD_WAIT:
                    // Received slots of the frame that just ended are valid on its falling edge
                    if (valid_ne) begin
                        if (rd_match) begin
                            rd_data  <= in_slt2[19:4];
                            rd_valid <= 1'b1;
                            state    <= IDLE;
                        end else if (fcnt == LAST_FRAME) begin
                            rd_timeout <= 1'b1;
                            state      <= IDLE;
                        end else if (fcnt != 8'hff) begin
                            fcnt <= fcnt + 8'd1;
                        end
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ac97_cra_queue.sv
// tb_ac97_cra_queue: transaction-level model plus directed vectors for ac97_cra_queue
module tb_ac97_cra_queue;
    logic        clk = 1'b0;
    logic        rst, cmd_we, valid;
    logic [31:0] cmd_din;
    logic [19:0] in_slt1, in_slt2;

    logic        full, drop, cv, cw, wd, rv, rt, bsy;
    logic [2:0]  lvl;
    logic [19:0] s1, s2;
    logic [15:0] rd;

    logic        z_full, z_drop, z_cv, z_cw, z_wd, z_rv, z_rt, z_bsy;
    logic [2:0]  z_lvl;
    logic [19:0] z_s1, z_s2;
    logic [15:0] z_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ac97_cra_queue #(.DEPTH(4), .AW(2), .TIMEOUT_FRAMES(4), .ADDR_CHECK(1'b1)) u1 (
        .clk(clk), .rst(rst), .cmd_we(cmd_we), .cmd_din(cmd_din), .cmd_full(full),
        .cmd_level(lvl), .cmd_drop(drop), .valid(valid), .out_slt1(s1), .out_slt2(s2),
        .in_slt1(in_slt1), .in_slt2(in_slt2), .crac_valid(cv), .crac_wr(cw),
        .wr_done(wd), .rd_valid(rv), .rd_data(rd), .rd_timeout(rt), .busy(bsy));

    ac97_cra_queue #(.DEPTH(4), .AW(2), .TIMEOUT_FRAMES(4), .ADDR_CHECK(1'b0)) u0 (
        .clk(clk), .rst(rst), .cmd_we(cmd_we), .cmd_din(cmd_din), .cmd_full(z_full),
        .cmd_level(z_lvl), .cmd_drop(z_drop), .valid(valid), .out_slt1(z_s1), .out_slt2(z_s2),
        .in_slt1(in_slt1), .in_slt2(in_slt2), .crac_valid(z_cv), .crac_wr(z_cw),
        .wr_done(z_wd), .rd_valid(z_rv), .rd_data(z_rd), .rd_timeout(z_rt), .busy(z_bsy));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of pending commands, the command being served, and what it is waiting for
    localparam int P_IDLE = 0, P_FRAME = 1, P_SENDING = 2, P_REPLY = 3;
    logic [31:0] m_q[$];
    logic [31:0] m_cur = '0;
    int          m_phase = P_IDLE;
    int          m_left = 0;
    logic        m_vprev = 1'b0;
    logic        m_drop = 1'b0, m_wd = 1'b0, m_rv = 1'b0, m_rt = 1'b0;
    logic [15:0] m_rd = '0;

    always @(posedge clk) begin
        bit rise, fall, take, accept;
        if (rst) begin
            m_q.delete();
            m_cur = '0; m_phase = P_IDLE; m_vprev = 1'b0;
            m_drop = 1'b0; m_wd = 1'b0; m_rv = 1'b0; m_rt = 1'b0; m_rd = '0;
        end else begin
            rise = valid && !m_vprev;
            fall = !valid && m_vprev;
            m_vprev = valid;
            m_drop = cmd_we && m_q.size() == 4;
            accept = cmd_we && m_q.size() < 4;
            take = m_phase == P_IDLE && m_q.size() > 0 && !valid;
            m_wd = 1'b0; m_rv = 1'b0; m_rt = 1'b0;
            if (m_phase == P_IDLE && take) begin
                m_cur = m_q.pop_front();
                m_phase = P_FRAME;
            end else if (m_phase == P_FRAME && rise) begin
                m_phase = P_SENDING;
            end else if (m_phase == P_SENDING && fall) begin
                if (m_cur[31]) begin
                    m_phase = P_REPLY;
                    m_left = 4;
                end else begin
                    m_wd = 1'b1;
                    m_phase = P_IDLE;
                end
            end else if (m_phase == P_REPLY && fall) begin
                if (in_slt1[18:12] == m_cur[22:16]) begin
                    m_rd = in_slt2[19:4];
                    m_rv = 1'b1;
                    m_phase = P_IDLE;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_rt = 1'b1;
                        m_phase = P_IDLE;
                    end
                end
            end
            if (accept) m_q.push_back(cmd_din);
        end
    end

    always @(posedge clk) begin
        logic in_cmd;
        #1;
        in_cmd = m_phase == P_FRAME || m_phase == P_SENDING;
        chk("cmp_level", 32'(lvl), 32'(m_q.size()));
        chk("cmp_full", 32'(full), 32'(m_q.size() == 4));
        chk("cmp_drop", 32'(drop), 32'(m_drop));
        chk("cmp_slt1", 32'(s1), 32'({m_cur[31], m_cur[22:16], 12'h0}));
        chk("cmp_slt2", 32'(s2), 32'(m_cur[31] ? 20'h0 : {m_cur[15:0], 4'h0}));
        chk("cmp_crac_valid", 32'(cv), 32'(in_cmd));
        chk("cmp_crac_wr", 32'(cw), 32'(in_cmd && !m_cur[31]));
        chk("cmp_wr_done", 32'(wd), 32'(m_wd));
        chk("cmp_rd_valid", 32'(rv), 32'(m_rv));
        chk("cmp_rd_data", 32'(rd), 32'(m_rd));
        chk("cmp_rd_timeout", 32'(rt), 32'(m_rt));
        chk("cmp_busy", 32'(bsy), 32'(m_phase != P_IDLE));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] c);
        cmd_we = 1'b1;
        cmd_din = c;
        tick();
        cmd_we = 1'b0;
    endtask

    // Frame of n valid cycles; returns one cycle after valid falls
    task automatic frame(input int n);
        valid = 1'b1;
        repeat (n) tick();
        valid = 1'b0;
        tick();
    endtask

    logic [15:0] wdat [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};

    initial begin
        rst = 1'b1; cmd_we = 1'b0; cmd_din = '0; valid = 1'b0; in_slt1 = '0; in_slt2 = '0;
        tick(); tick();
        chk("rst_busy", 32'(bsy), 0);
        chk("rst_level", 32'(lvl), 0);
        chk("rst_slt1", 32'(s1), 0);
        chk("rst_rd_data", 32'(rd), 0);
        rst = 1'b0;

        push(32'h0002_1234);
        chk("t1_level_first", 32'(lvl), 1);
        tick();
        chk("t1_crac_wr", 32'(cw), 1);
        chk("t1_slt1", 32'(s1), 32'h02000);
        chk("t1_slt2", 32'(s2), 32'h12340);
        chk("t1_busy", 32'(bsy), 1);
        frame(10);
        chk("t1_wr_done", 32'(wd), 1);
        chk("t1_busy_after", 32'(bsy), 0);
        tick();
        chk("t1_wr_done_single", 32'(wd), 0);

        push(32'h8026_0000);
        tick();
        chk("t2_slt1", 32'(s1), 32'hA6000);
        chk("t2_slt2", 32'(s2), 0);
        chk("t2_crac_wr", 32'(cw), 0);
        chk("t2_crac_valid", 32'(cv), 1);
        frame(10);
        chk("t2_waiting", 32'(bsy), 1);
        chk("t2_crac_valid_off", 32'(cv), 0);
        in_slt1 = 20'h26000; in_slt2 = 20'hABCD0;
        frame(8);
        chk("t2_rd_valid", 32'(rv), 1);
        chk("t2_rd_data", 32'(rd), 32'hABCD);
        chk("t2_busy", 32'(bsy), 0);
        tick();
        chk("t2_rd_valid_single", 32'(rv), 0);

        in_slt1 = '0; in_slt2 = '0;
        push(32'h8026_0000);
        tick();
        frame(6);
        in_slt1 = 20'h7C000; in_slt2 = 20'h55550;
        for (int i = 0; i < 4; i++) begin
            frame(6);
            chk("t3_timeout", 32'(rt), 32'(i == 3));
            chk("t3_busy", 32'(bsy), 32'(i != 3));
        end
        chk("t3_rd_data_held", 32'(rd), 32'hABCD);
        tick();
        chk("t3_timeout_single", 32'(rt), 0);

        push({16'h0001, wdat[0]});
        tick();
        for (int i = 1; i < 5; i++) push({16'h0001, wdat[i]});
        chk("t4_level", 32'(lvl), 4);
        chk("t4_full", 32'(full), 1);
        chk("t4_no_drop", 32'(drop), 0);
        push(32'h0001_6666);
        chk("t4_drop", 32'(drop), 1);
        chk("t4_level_kept", 32'(lvl), 4);
        for (int i = 0; i < 5; i++) begin
            chk("t4_order", 32'(s2), 32'({wdat[i], 4'h0}));
            frame(6);
            chk("t4_wr_done", 32'(wd), 1);
            tick();
        end
        chk("t4_drained", 32'(bsy), 0);
        chk("t4_level_empty", 32'(lvl), 0);

        in_slt1 = '0; in_slt2 = '0;
        push(32'h8026_0000);
        tick();
        for (int i = 0; i < 3; i++) push(32'h0007_0000 + 32'(i));
        frame(6);
        chk("t5_pre_level", 32'(lvl), 3);
        chk("t5_pre_busy", 32'(bsy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_level", 32'(lvl), 0);
        chk("t5_busy", 32'(bsy), 0);
        chk("t5_slt1", 32'(s1), 0);
        chk("t5_rd_data", 32'(rd), 0);
        in_slt1 = 20'h26000; in_slt2 = 20'hABCD0;
        frame(6);
        chk("t5_no_rd_valid", 32'(rv), 0);
        chk("t5_no_wr_done", 32'(wd), 0);
        chk("t5_no_timeout", 32'(rt), 0);

        in_slt1 = '0; in_slt2 = '0;
        push(32'h8026_0000);
        tick();
        frame(6);
        in_slt1 = 20'h7C000; in_slt2 = 20'h12340;
        frame(6);
        chk("t6_any_rd_valid", 32'(z_rv), 1);
        chk("t6_any_rd_data", 32'(z_rd), 32'h1234);
        chk("t6_checked_rd_valid", 32'(rv), 0);
        chk("t6_checked_busy", 32'(bsy), 1);
        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
